// File: rtl/nios_core_ledg_drv.sv
// rtl/nios_core_ledg_drv.sv - Avalon-MM LED dimmer/blinker between a PIO out_port and the LED pins
//
// Sits between an upstream PIO LED pattern and the board LEDs and applies a
// frame-synchronous PWM dimmer plus an optional frame-counted blinker.
//
// Register map (word addresses):
//   0 CTRL          bit0 EN, bit1 BLINK_EN
//   1 DUTY          [7:0]
//   2 BLINK_PERIOD  [15:0], in PWM frames
//   3 STATUS (RO)   bit0 PHASE (1 = blink ON), [15:8] PWM_CNT
//
// Parameters:
//   PRESCALE  clk cycles per PWM tick minus one (0..65535)
//   DUTY_RST  reset value of DUTY and of the active duty
//
// Ports:
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     Avalon-MM word address
//   chipselect  Avalon-MM select
//   write_n     Avalon-MM write strobe, active-low
//   writedata   Avalon-MM write data
//   readdata    Avalon-MM read data, combinational, zero wait states
//   led_in      LED pattern from the PIO
//   led_out     registered, dimmed/blinked LED pattern
//
// Build option:
//   NIOS_CORE_LEDG_DRV_BLINK_EN  when defined, builds the blink FSM, its
//   frame counter and the BLINK_PERIOD register. When undefined the LEDs
//   are never blanked by blinking, address 2 and CTRL bit1 read as zero and
//   writes to them are dropped.

module nios_core_ledg_drv #(
    parameter int unsigned PRESCALE = 195,
    parameter int unsigned DUTY_RST = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [7:0]  led_in,
    output logic [7:0]  led_out
);

    localparam logic [15:0] PRESCALE_V = 16'(PRESCALE);
    localparam logic [7:0]  DUTY_RST_V = 8'(DUTY_RST);

    // ------------------------------------------------------------------
    // Bus write decode
    // ------------------------------------------------------------------
    logic wr_en;
    logic wr_ctrl;
    logic wr_duty;

    assign wr_en   = chipselect & ~write_n;
    assign wr_ctrl = wr_en & (address == 2'd0);
    assign wr_duty = wr_en & (address == 2'd1);

    // ------------------------------------------------------------------
    // Register / counter state
    // ------------------------------------------------------------------
    logic        ctrl_en_q,    ctrl_en_d;
    logic [7:0]  duty_q,       duty_d;
    logic [7:0]  act_duty_q,   act_duty_d;
    logic [15:0] presc_q,      presc_d;
    logic [7:0]  pwm_cnt_q,    pwm_cnt_d;
    logic [7:0]  led_out_q,    led_out_d;

    logic tick;
    logic frame_end;
    logic pwm_on;
    logic phase_on;

    // The prescaler and PWM counter free-run regardless of EN so the frame
    // grid stays fixed while the LEDs are switched off and on again.
    assign tick      = (presc_q == PRESCALE_V);
    assign frame_end = tick & (pwm_cnt_q == 8'hFF);

    // Duty 255 is fully on: without the explicit compare the last count of
    // every frame would still be dark.
    assign pwm_on = (act_duty_q == 8'hFF) | (pwm_cnt_q < act_duty_q);

    always_comb begin
        ctrl_en_d  = ctrl_en_q;
        duty_d     = duty_q;
        act_duty_d = act_duty_q;
        presc_d    = presc_q + 16'd1;
        pwm_cnt_d  = pwm_cnt_q;

        if (wr_ctrl) begin
            ctrl_en_d = writedata[0];
        end
        if (wr_duty) begin
            duty_d = writedata[7:0];
        end

        if (tick) begin
            presc_d   = 16'd0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end

        // Active duty only changes on a frame boundary so a frame is never
        // cut short or stretched. duty_d (not duty_q) is loaded so that a
        // DUTY write landing on the boundary edge applies to the new frame.
        if (frame_end) begin
            act_duty_d = duty_d;
        end
    end

    assign led_out_d = led_in & {8{ctrl_en_q & pwm_on & phase_on}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en_q  <= 1'b0;
            duty_q     <= DUTY_RST_V;
            act_duty_q <= DUTY_RST_V;
            presc_q    <= 16'd0;
            pwm_cnt_q  <= 8'd0;
            led_out_q  <= 8'd0;
        end else begin
            ctrl_en_q  <= ctrl_en_d;
            duty_q     <= duty_d;
            act_duty_q <= act_duty_d;
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            led_out_q  <= led_out_d;
        end
    end

    assign led_out = led_out_q;

    // Bits of writedata that no register ever stores.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:16];

`ifdef NIOS_CORE_LEDG_DRV_BLINK_EN
    // ------------------------------------------------------------------
    // Blink FSM: toggles ON/OFF every BLINK_PERIOD PWM frames
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_ON  = 1'b0,
        ST_OFF = 1'b1
    } blink_state_e;

    blink_state_e state_q, state_d;
    logic        ctrl_blink_q,   ctrl_blink_d;
    logic [15:0] blink_period_q, blink_period_d;
    logic [15:0] frame_cnt_q,    frame_cnt_d;
    logic        wr_period;

    assign wr_period    = wr_en & (address == 2'd2);
    assign ctrl_blink_d = wr_ctrl ? writedata[1] : ctrl_blink_q;

    always_comb begin
        state_d        = state_q;
        frame_cnt_d    = frame_cnt_q;
        blink_period_d = blink_period_q;

        // A new period restarts the blink cycle from a full ON phase.
        if (wr_period) begin
            blink_period_d = writedata[15:0];
            state_d        = ST_ON;
            frame_cnt_d    = 16'd0;
        end else if (!ctrl_blink_q || (blink_period_q == 16'd0)) begin
            state_d     = ST_ON;
            frame_cnt_d = 16'd0;
        end else if (frame_end) begin
            if (frame_cnt_q == (blink_period_q - 16'd1)) begin
                frame_cnt_d = 16'd0;
                case (state_q)
                    ST_ON:   state_d = ST_OFF;
                    ST_OFF:  state_d = ST_ON;
                    default: state_d = ST_ON;
                endcase
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_ON;
            ctrl_blink_q   <= 1'b0;
            blink_period_q <= 16'd0;
            frame_cnt_q    <= 16'd0;
        end else begin
            state_q        <= state_d;
            ctrl_blink_q   <= ctrl_blink_d;
            blink_period_q <= blink_period_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign phase_on = (state_q == ST_ON);
`else
    // No blinker: the LEDs are always in the ON phase.
    assign phase_on = 1'b1;

    logic unused_wdata_blink;
    assign unused_wdata_blink = ^writedata[15:8];
`endif

    // ------------------------------------------------------------------
    // Read mux: purely combinational on address, chipselect not required
    // ------------------------------------------------------------------
    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: begin
                readdata[0] = ctrl_en_q;
`ifdef NIOS_CORE_LEDG_DRV_BLINK_EN
                readdata[1] = ctrl_blink_q;
`endif
            end
            2'd1: readdata[7:0] = duty_q;
            2'd2: begin
`ifdef NIOS_CORE_LEDG_DRV_BLINK_EN
                readdata[15:0] = blink_period_q;
`endif
            end
            2'd3: begin
                readdata[0]    = phase_on;
                readdata[15:8] = pwm_cnt_q;
            end
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_nios_core_ledg_drv.sv
// tb/tb_nios_core_ledg_drv.sv - self-checking bench for nios_core_ledg_drv

module tb_nios_core_ledg_drv;

`ifdef NIOS_CORE_LEDG_DRV_BLINK_EN
    localparam bit HAS_BLINK = 1'b1;
`else
    localparam bit HAS_BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  led_in;
    logic [31:0] readdata,   readdata_p;
    logic [7:0]  led_out,    led_out_p;

    always #5 clk = ~clk;

    nios_core_ledg_drv #(.PRESCALE(0), .DUTY_RST(255)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .led_in(led_in), .led_out(led_out)
    );

    nios_core_ledg_drv #(.PRESCALE(2), .DUTY_RST(100)) u_dut_p (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_p),
        .led_in(led_in), .led_out(led_out_p)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[9];

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
        logic [31:0] exp_p;
    } rst_vec_t;
    rst_vec_t rst_vecs[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired", nm);
    endtask

    task automatic sb_push(input string nm, input logic [31:0] exp);
        sb_q.push_back('{nm, exp});
    endtask

    task automatic sb_pop_check(input logic [31:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            fail_now("scoreboard empty");
        end else begin
            e = sb_q.pop_front();
            check(e.nm, act, e.exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d,
                             input logic cs, input logic wn);
        @(negedge clk);
        address = a; writedata = d; chipselect = cs; write_n = wn;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic read_now(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_cnt(input logic [7:0] c, input string nm);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            address = 2'd3;
            #1;
            if (readdata[15:8] == c) break;
        end
        if (k == 2000) fail_now(nm);
    endtask

    task automatic steady(input int n, input logic [7:0] exp, input string nm);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (led_out !== exp) bad++;
        end
        check(nm, bad, 0);
    endtask

    // Measures one PWM frame on u_dut (PRESCALE=0). The window is the 256
    // samples following a sample with PWM_CNT==0; a sample at count c shows
    // the output computed from count c-1. Optionally writes DUTY once: either
    // before the window (pre, on the cycle just ahead of the boundary) or
    // inside it when the sampled count equals wr_cnt.
    task automatic window(input bit pre, input int wr_cnt, input logic [7:0] wr_data,
                          input int exp_on, input string nm);
        bit   written = 1'b0;
        bit   started = 1'b0;
        bit   exp_b;
        int   n = 0, on = 0, bad = 0;
        int   cnt;
        for (int g = 0; g < 2000 && n < 256; g++) begin
            @(negedge clk);
            address = 2'd3; chipselect = 1'b0; write_n = 1'b1;
            #1;
            cnt = int'(readdata[15:8]);
            if (started) begin
                n++;
                exp_b = (exp_on == 255) || (cnt >= 1 && cnt <= exp_on);
                if (led_out == 8'hFF) on++;
                if ((led_out == 8'hFF) != exp_b || (led_out != 8'h00 && led_out != 8'hFF)) bad++;
            end else if (cnt == 0 && (!pre || written)) begin
                started = 1'b1;
            end
            if (!written && wr_cnt >= 0 && cnt == wr_cnt && (pre ? !started : started)) begin
                address = 2'd1; writedata = {24'd0, wr_data}; chipselect = 1'b1; write_n = 1'b0;
                written = 1'b1;
            end
        end
        chipselect = 1'b0; write_n = 1'b1;
        if (n < 256) begin
            fail_now({nm, " window"});
        end else begin
            check({nm, " on_count"}, on, (exp_on == 255) ? 256 : exp_on);
            check({nm, " pattern_errs"}, bad, 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  c1;

        rst_vecs[0] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
        rst_vecs[1] = '{2'd1, 32'h0000_00FF, 32'h0000_0064};
        rst_vecs[2] = '{2'd2, 32'h0000_0000, 32'h0000_0000};
        rst_vecs[3] = '{2'd3, 32'h0000_0001, 32'h0000_0001};

        vecs[0] = '{1'b1, 1'b0, 2'd1, 32'h1234_5680, 2'd1, 32'h0000_0080};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 2'd0, HAS_BLINK ? 32'd3 : 32'd1};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 32'h0001_FFFF, 2'd2, HAS_BLINK ? 32'h0000_FFFF : 32'd0};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 2'd0, HAS_BLINK ? 32'd3 : 32'd1};
        vecs[4] = '{1'b0, 1'b0, 2'd1, 32'h0000_0011, 2'd1, 32'h0000_0080};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 32'h0000_0022, 2'd1, 32'h0000_0080};
        vecs[6] = '{1'b1, 1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
        vecs[7] = '{1'b1, 1'b0, 2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000};
        vecs[8] = '{1'b1, 1'b0, 2'd1, 32'h0000_00FF, 2'd1, 32'h0000_00FF};

        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; led_in = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values of both instances
        #1;
        check("rst led_out", led_out, 8'h00);
        check("rst led_out_p", led_out_p, 8'h00);
        foreach (rst_vecs[i]) begin
            address = rst_vecs[i].addr;
            #1;
            check($sformatf("rst rd a%0d", rst_vecs[i].addr), readdata, rst_vecs[i].exp);
            check($sformatf("rst rd_p a%0d", rst_vecs[i].addr), readdata_p, rst_vecs[i].exp_p);
        end

        // Prescaler / PWM counter progression from reset release
        @(negedge clk);
        reset_n = 1'b1;
        address = 2'd3;
        repeat (30) @(negedge clk);
        #1;
        check("cnt k30", readdata, 32'h0000_1E01);
        check("cnt_p k30", readdata_p, 32'h0000_0A01);
        @(negedge clk); #1;
        check("cnt_p k31", readdata_p, 32'h0000_0A01);
        repeat (2) @(negedge clk);
        #1;
        check("cnt_p k33", readdata_p, 32'h0000_0B01);

        // Register access table
        foreach (vecs[i]) begin
            sb_push($sformatf("reg vec%0d", i), vecs[i].exp);
            bus_write(vecs[i].waddr, vecs[i].wdata, vecs[i].cs, vecs[i].wn);
            read_now(vecs[i].raddr, rd);
            sb_pop_check(rd);
        end

        // EN with default duty 255, led_in passes through
        wait_cnt(8'd0, "sync before enable");
        led_in = 8'hA5;
        bus_write(2'd0, 32'd1, 1'b1, 1'b0);
        sb_push("enable A5 within 2clk", 32'hA5);
        @(negedge clk); #1;
        sb_pop_check({24'd0, led_out});
        steady(300, 8'hA5, "steady A5");

        // One clk latency from led_in
        @(negedge clk);
        led_in = 8'h3C;
        #1;
        check("no comb path led_in", led_out, 8'hA5);
        sb_push("led_in latency", 32'h3C);
        @(negedge clk); #1;
        sb_pop_check({24'd0, led_out});

        // PWM duty frames
        led_in = 8'hFF;
        bus_write(2'd1, 32'd64, 1'b1, 1'b0);
        window(1'b0, -1, 8'd0, 64, "duty64");
        window(1'b1, 255, 8'd16, 16, "duty16 at boundary");
        bus_write(2'd1, 32'd128, 1'b1, 1'b0);
        window(1'b0, -1, 8'd0, 128, "duty128");
        window(1'b0, 50, 8'd0, 128, "duty0 written mid-frame");
        window(1'b0, -1, 8'd0, 0, "duty0 next frame");
        bus_write(2'd1, 32'd255, 1'b1, 1'b0);
        window(1'b0, -1, 8'd0, 255, "duty255");

        // Asynchronous reset mid-frame
        wait_cnt(8'd77, "sync before reset");
        check("pre-reset led on", led_out, 8'hFF);
        reset_n = 1'b0;
        #1;
        check("async rst led_out", led_out, 8'h00);
        check("async rst status", readdata, 32'h0000_0001);
        read_now(2'd1, rd);
        check("async rst duty", rd, 32'h0000_00FF);
        read_now(2'd0, rd);
        check("async rst ctrl", rd, 32'h0000_0000);
        @(negedge clk);
        reset_n = 1'b1;

        // EN=0 blanks next edge while the counters keep running
        bus_write(2'd0, 32'd1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        address = 2'd3; #1;
        c1 = readdata[15:8];
        check("en1 led on", led_out, 8'hFF);
        address = 2'd0; writedata = 32'd0; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        sb_push("en0 led off", 32'h00);
        @(negedge clk);
        address = 2'd3; #1;
        sb_pop_check({24'd0, led_out});
        check("en0 cnt runs", readdata[15:8], c1 + 8'd2);

`ifdef NIOS_CORE_LEDG_DRV_BLINK_EN
        // Blink: period 2 -> two frames on, two frames off
        bus_write(2'd0, 32'd3, 1'b1, 1'b0);
        wait_cnt(8'd10, "sync before period");
        bus_write(2'd2, 32'd2, 1'b1, 1'b0);
        for (int f = 0; f < 8; f++) begin
            wait_cnt(8'd128, "blink frame");
            check($sformatf("blink phase f%0d", f), readdata[0], ((f % 4) < 2) ? 1'b1 : 1'b0);
            check($sformatf("blink led f%0d", f), led_out, ((f % 4) < 2) ? 8'hFF : 8'h00);
        end
        reset_n = 1'b0;
        #1;
        check("blink rst led_out", led_out, 8'h00);
        check("blink rst status", readdata, 32'h0000_0001);
        read_now(2'd2, rd);
        check("blink rst period", rd, 32'h0000_0000);
        read_now(2'd0, rd);
        check("blink rst ctrl", rd, 32'h0000_0000);
        read_now(2'd1, rd);
        check("blink rst duty", rd, 32'h0000_00FF);
        @(negedge clk);
        reset_n = 1'b1;
`else
        // No blinker built: addr2 and CTRL bit1 are dropped
        bus_write(2'd2, 32'h0000_FFFF, 1'b1, 1'b0);
        read_now(2'd2, rd);
        check("noblink addr2", rd, 32'h0000_0000);
        bus_write(2'd0, 32'd3, 1'b1, 1'b0);
        read_now(2'd0, rd);
        check("noblink ctrl", rd, 32'h0000_0001);
        @(negedge clk);
        steady(700, 8'hFF, "noblink steady on");
        address = 2'd3; #1;
        check("noblink phase", readdata[0], 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/nios_core_ledg_drv.md
NIOS_CORE_LEDG_DRV -- requirements
Module: nios_core_ledg_drv

Interface
REQ-001 SHALL have parameter PRESCALE, default 195, meaning clk cycles per PWM tick minus one (range 0..65535).
REQ-002 SHALL have parameter DUTY_RST, default 255, meaning the reset value of the DUTY register.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 writedata  input  32  Avalon-MM write data.
REQ-009 readdata  output  32  Avalon-MM read data; unused bits zero.
REQ-010 led_in  input  8  LED pattern from the upstream PIO out_port.
REQ-011 led_out  output  8  dimmed/blinked pattern to the LED pins.

Function
REQ-012 Registers: addr0 CTRL (bit0 EN, bit1 BLINK_EN); addr1 DUTY[7:0]; addr2 BLINK_PERIOD[15:0]; addr3 STATUS, read-only (bit0 PHASE, bits[15:8] PWM_CNT).
REQ-013 A write SHALL occur when chipselect=1, write_n=0; the addressed register updates on that edge; writes to addr3 are ignored.
REQ-014 readdata SHALL be combinationally decoded from address, independent of chipselect, with zero wait states.
REQ-015 Prescaler SHALL count 0..PRESCALE and wrap to 0; tick asserts for one cycle when the count equals PRESCALE.
REQ-016 PWM_CNT SHALL increment by 1 on each tick and wrap from 255 to 0; that wrap is a frame boundary.
REQ-017 Active duty SHALL load from DUTY only at a frame boundary, so a DUTY write never changes the current frame.
REQ-018 pwm_on SHALL equal (active duty == 255) OR (PWM_CNT < active duty); duty 0 yields permanently off.
REQ-019 Blink FSM states ON and OFF: a frame counter increments each frame boundary; when it reaches BLINK_PERIOD-1 the FSM toggles state and the counter clears.
REQ-020 BLINK_PERIOD=0 or BLINK_EN=0 SHALL force state ON and clear the frame counter; PHASE reads 1 in ON.
REQ-021 Writing BLINK_PERIOD SHALL clear the frame counter and force state ON on the same edge.
REQ-022 led_out SHALL be registered: led_out <= led_in AND {8{EN AND pwm_on AND (state==ON)}}; one clk latency from led_in.
REQ-023 EN=0 SHALL drive led_out to 0 on the next edge, while prescaler and PWM_CNT keep running.
REQ-024 A simultaneous register write and frame boundary SHALL make the new DUTY take effect immediately at that boundary.

Reset
REQ-025 On reset_n=0: CTRL=0, DUTY=DUTY_RST, active duty=DUTY_RST, BLINK_PERIOD=0, prescaler=0, PWM_CNT=0, frame counter=0, FSM=ON, led_out=0.
REQ-026 Reset asserted mid-frame or mid-blink SHALL take effect immediately, with no completion of the frame.

Configuration
REQ-027 Macro NIOS_CORE_LEDG_DRV_BLINK_EN defined: blink FSM, frame counter and BLINK_PERIOD register are present per REQ-019..021.
REQ-028 Macro undefined: no blink logic is built; FSM treated as constant ON; addr2 and CTRL bit1 read 0 and writes to them are ignored.

Verification
REQ-029 Reset, then write CTRL=1 with defaults, led_in=0xA5 -> led_out=0xA5 within 2 clk and steady (duty 255).
REQ-030 PRESCALE=0, DUTY=64, EN=1, led_in=0xFF -> led_out=0xFF for exactly 64 of every 256 cycles, starting at frame start.
REQ-031 Write DUTY=0 mid-frame with prior duty 128 -> current frame keeps 128 on-ticks; next frame led_out stays 0.
REQ-032 BLINK_EN=1, BLINK_PERIOD=2, duty 255 -> led_out alternates 2 frames on, 2 frames off; PHASE toggles accordingly.
REQ-033 Assert reset_n=0 mid-blink OFF phase -> led_out=0, STATUS reads 0x0001 immediately, all registers at reset values.
REQ-034 Build without NIOS_CORE_LEDG_DRV_BLINK_EN, write addr2=0xFFFF and CTRL=3 -> addr2 reads 0, CTRL reads 1, no blinking.
